// File: rtl/store_queue.sv
`default_nettype none
// ============================================================================
// Module      : store_queue
// Description : Circular store buffer between dispatch, the ALU FU and the
//               data cache: in-order alloc, out-of-order resolve, in-order
//               commit and drain. Define SQ_FWD_EN for store-to-load forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module store_queue #(
  parameter int SQ_DEPTH = 8,
  parameter int IDX_W    = $clog2(SQ_DEPTH),
  parameter int XLEN     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dispatch_valid,
  output logic [IDX_W-1:0]  sq_tail,
  output logic              sq_full,
  output logic              sq_empty,
  input  logic              exec_valid,
  input  logic [IDX_W-1:0]  exec_idx,
  input  logic [XLEN-1:0]   exec_addr,
  input  logic [XLEN-1:0]   exec_data,
  input  logic [3:0]        exec_usebytes,
  input  logic              retire_valid,
  input  logic              squash,
  output logic              mem_req_valid,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_data,
  output logic [3:0]        mem_req_usebytes,
  input  logic              mem_req_ready
`ifdef SQ_FWD_EN
  ,
  input  logic [XLEN-1:0]   ld_addr,
  input  logic [IDX_W:0]    ld_pos,
  output logic [3:0]        ld_fwd_bytes,
  output logic [XLEN-1:0]   ld_fwd_data
`endif
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_ALLOC  = 2'd1,
    S_READY  = 2'd2,
    S_COMMIT = 2'd3
  } entry_state_t;

  localparam logic [IDX_W:0] c_ptr_zero   = '0;
  localparam logic [IDX_W:0] c_ptr_one    = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] c_full_count = (IDX_W+1)'(SQ_DEPTH);

  entry_state_t      r_state     [SQ_DEPTH];
  entry_state_t      w_state_nxt [SQ_DEPTH];
  logic [XLEN-1:0]   r_addr      [SQ_DEPTH];
  logic [XLEN-1:0]   r_data      [SQ_DEPTH];
  logic [3:0]        r_bytes     [SQ_DEPTH];

  logic [IDX_W:0]    r_head;
  logic [IDX_W:0]    r_commit;
  logic [IDX_W:0]    r_tail;
  logic [IDX_W:0]    w_commit_nxt;
  logic [IDX_W:0]    w_count;
  logic [IDX_W-1:0]  w_head_idx;
  logic [IDX_W-1:0]  w_commit_idx;
  logic [IDX_W-1:0]  w_tail_idx;

  logic              w_dispatch;
  logic              w_exec;
  logic              w_retire;
  logic              w_drain;

  assign w_head_idx   = r_head[IDX_W-1:0];
  assign w_commit_idx = r_commit[IDX_W-1:0];
  assign w_tail_idx   = r_tail[IDX_W-1:0];
  assign w_count      = r_tail - r_head;

  assign sq_tail  = w_tail_idx;
  assign sq_full  = (w_count == c_full_count);
  assign sq_empty = (w_count == c_ptr_zero);

  assign mem_req_valid    = (r_state[w_head_idx] == S_COMMIT);
  assign mem_req_addr     = r_addr[w_head_idx];
  assign mem_req_data     = r_data[w_head_idx];
  assign mem_req_usebytes = r_bytes[w_head_idx];

  assign w_dispatch = dispatch_valid && !sq_full && !squash;
  assign w_exec     = exec_valid && (r_state[exec_idx] == S_ALLOC) && !squash;
  assign w_retire   = retire_valid && (r_state[w_commit_idx] == S_READY);
  assign w_drain    = mem_req_valid && mem_req_ready;

  assign w_commit_nxt = w_retire ? (r_commit + c_ptr_one) : r_commit;

  // Priority per entry: drain, retire, squash, exec, dispatch. The drain,
  // retire and dispatch targets can never alias given their required states.
  always_comb begin
    for (int i = 0; i < SQ_DEPTH; i++) begin
      w_state_nxt[i] = r_state[i];
      if (w_drain && (w_head_idx == IDX_W'(i))) begin
        w_state_nxt[i] = S_FREE;
      end else if (w_retire && (w_commit_idx == IDX_W'(i))) begin
        w_state_nxt[i] = S_COMMIT;
      end else if (squash && ((r_state[i] == S_ALLOC) || (r_state[i] == S_READY))) begin
        w_state_nxt[i] = S_FREE;
      end else if (w_exec && (exec_idx == IDX_W'(i))) begin
        w_state_nxt[i] = S_READY;
      end else if (w_dispatch && (w_tail_idx == IDX_W'(i))) begin
        w_state_nxt[i] = S_ALLOC;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        r_state[i] <= S_FREE;
      end
    end else begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        r_state[i] <= w_state_nxt[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        r_addr[i]  <= '0;
        r_data[i]  <= '0;
        r_bytes[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        if (w_exec && (exec_idx == IDX_W'(i))) begin
          r_addr[i]  <= exec_addr;
          r_data[i]  <= exec_data;
          r_bytes[i] <= exec_usebytes;
        end
      end
    end
  end

  // Squash rewinds tail onto the post-retire commit pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head   <= '0;
      r_commit <= '0;
      r_tail   <= '0;
    end else begin
      r_commit <= w_commit_nxt;
      if (squash) begin
        r_tail <= w_commit_nxt;
      end else if (w_dispatch) begin
        r_tail <= r_tail + c_ptr_one;
      end
      if (w_drain) begin
        r_head <= r_head + c_ptr_one;
      end
    end
  end

`ifdef SQ_FWD_EN
  logic [IDX_W:0]   w_ld_span;
  logic [IDX_W:0]   w_fwd_off;
  logic [IDX_W-1:0] w_fwd_idx;
  logic             w_unused_ld_lo;

  assign w_ld_span      = ld_pos - r_head;
  assign w_unused_ld_lo = ^ld_addr[1:0];

  // Walk oldest to youngest so later matches overwrite earlier lanes.
  always_comb begin
    ld_fwd_bytes = '0;
    ld_fwd_data  = '0;
    w_fwd_off    = '0;
    w_fwd_idx    = '0;
    for (int k = 0; k < SQ_DEPTH; k++) begin
      w_fwd_off = (IDX_W+1)'(k);
      w_fwd_idx = w_head_idx + IDX_W'(k);
      if ((w_fwd_off < w_ld_span) &&
          ((r_state[w_fwd_idx] == S_READY) || (r_state[w_fwd_idx] == S_COMMIT)) &&
          (r_addr[w_fwd_idx][XLEN-1:2] == ld_addr[XLEN-1:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (r_bytes[w_fwd_idx][b]) begin
            ld_fwd_bytes[b]       = 1'b1;
            ld_fwd_data[8*b +: 8] = r_data[w_fwd_idx][8*b +: 8];
          end
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_queue
// Description : Table-driven directed bench for store_queue (SQ_FWD_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_queue;

  logic        clock;
  logic        reset;
  logic        dispatch_valid;
  logic [2:0]  sq_tail;
  logic        sq_full;
  logic        sq_empty;
  logic        exec_valid;
  logic [2:0]  exec_idx;
  logic [31:0] exec_addr;
  logic [31:0] exec_data;
  logic [3:0]  exec_usebytes;
  logic        retire_valid;
  logic        squash;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_usebytes;
  logic        mem_req_ready;
`ifdef SQ_FWD_EN
  logic [31:0] ld_addr;
  logic [3:0]  ld_pos;
  logic [3:0]  ld_fwd_bytes;
  logic [31:0] ld_fwd_data;
`endif

  int n_checks;
  int n_fail;

  store_queue #(.SQ_DEPTH(8), .XLEN(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .dispatch_valid   (dispatch_valid),
    .sq_tail          (sq_tail),
    .sq_full          (sq_full),
    .sq_empty         (sq_empty),
    .exec_valid       (exec_valid),
    .exec_idx         (exec_idx),
    .exec_addr        (exec_addr),
    .exec_data        (exec_data),
    .exec_usebytes    (exec_usebytes),
    .retire_valid     (retire_valid),
    .squash           (squash),
    .mem_req_valid    (mem_req_valid),
    .mem_req_addr     (mem_req_addr),
    .mem_req_data     (mem_req_data),
    .mem_req_usebytes (mem_req_usebytes),
    .mem_req_ready    (mem_req_ready)
`ifdef SQ_FWD_EN
    ,
    .ld_addr          (ld_addr),
    .ld_pos           (ld_pos),
    .ld_fwd_bytes     (ld_fwd_bytes),
    .ld_fwd_data      (ld_fwd_data)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        d;
    logic        ev;
    logic [2:0]  ei;
    logic [31:0] ea;
    logic [31:0] ed;
    logic [3:0]  eb;
    logic        rt;
    logic        sq;
    logic        rdy;
    logic [2:0]  et;
    logic        ef;
    logic        ee;
    logic        emv;
    logic [31:0] ema;
    logic [31:0] emd;
    logic [3:0]  emb;
  } vec_t;

  vec_t vecs[$];

  // Inputs: dispatch, exec valid/idx/addr/data/bytes, retire, squash, ready.
  // Expected: sq_tail, full, empty, mem valid, mem addr/data/bytes (if valid).
  function automatic vec_t mk(input int d, input int ev, input int ei,
                              input logic [31:0] ea, input logic [31:0] ed, input int eb,
                              input int rt, input int sq, input int rdy,
                              input int et, input int ef, input int ee, input int emv,
                              input logic [31:0] ema, input logic [31:0] emd, input int emb);
    vec_t v;
    v.d = 1'(d);     v.ev = 1'(ev);   v.ei = 3'(ei);
    v.ea = ea;       v.ed = ed;       v.eb = 4'(eb);
    v.rt = 1'(rt);   v.sq = 1'(sq);   v.rdy = 1'(rdy);
    v.et = 3'(et);   v.ef = 1'(ef);   v.ee = 1'(ee);  v.emv = 1'(emv);
    v.ema = ema;     v.emd = emd;     v.emb = 4'(emb);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    dispatch_valid = 1'b0;
    exec_valid     = 1'b0;
    exec_idx       = '0;
    exec_addr      = '0;
    exec_data      = '0;
    exec_usebytes  = '0;
    retire_valid   = 1'b0;
    squash         = 1'b0;
    mem_req_ready  = 1'b0;
`ifdef SQ_FWD_EN
    ld_addr        = '0;
    ld_pos         = '0;
`endif
  endtask

  task automatic run_table(input string tag);
    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clock);
      dispatch_valid = vecs[n].d;
      exec_valid     = vecs[n].ev;
      exec_idx       = vecs[n].ei;
      exec_addr      = vecs[n].ea;
      exec_data      = vecs[n].ed;
      exec_usebytes  = vecs[n].eb;
      retire_valid   = vecs[n].rt;
      squash         = vecs[n].sq;
      mem_req_ready  = vecs[n].rdy;
      #1;
      chk($sformatf("%s%0d sq_tail", tag, n),  32'(sq_tail),       32'(vecs[n].et));
      chk($sformatf("%s%0d sq_full", tag, n),  32'(sq_full),       32'(vecs[n].ef));
      chk($sformatf("%s%0d sq_empty", tag, n), 32'(sq_empty),      32'(vecs[n].ee));
      chk($sformatf("%s%0d mem_valid", tag, n), 32'(mem_req_valid), 32'(vecs[n].emv));
      if (vecs[n].emv) begin
        chk($sformatf("%s%0d mem_addr", tag, n),  mem_req_addr,          vecs[n].ema);
        chk($sformatf("%s%0d mem_data", tag, n),  mem_req_data,          vecs[n].emd);
        chk($sformatf("%s%0d mem_bytes", tag, n), 32'(mem_req_usebytes), 32'(vecs[n].emb));
      end
    end
    vecs.delete();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    idle_inputs();

    #1;
    chk("rst sq_tail",   32'(sq_tail),          32'd0);
    chk("rst sq_empty",  32'(sq_empty),         32'd1);
    chk("rst sq_full",   32'(sq_full),          32'd0);
    chk("rst mem_valid", 32'(mem_req_valid),    32'd0);
    chk("rst mem_addr",  mem_req_addr,          32'd0);
    chk("rst mem_data",  mem_req_data,          32'd0);
    chk("rst mem_bytes", 32'(mem_req_usebytes), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Allocate, resolve out of order, retire, hold drain, then drain.
    vecs.push_back(mk(1,0,0,0,0,0,             0,0,0, 0,0,1,0, 0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,             0,0,0, 1,0,0,0, 0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,             0,0,0, 2,0,0,0, 0,0,0));
    vecs.push_back(mk(0,1,1,32'h1000,32'hAB00,2, 0,0,0, 3,0,0,0, 0,0,0));
    vecs.push_back(mk(0,1,0,32'h100,32'h11111111,15, 1,0,0, 3,0,0,0, 0,0,0));
    vecs.push_back(mk(0,1,2,32'h200,32'h22220000,12, 1,0,0, 3,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,             1,0,0, 3,0,0,1, 32'h100,32'h11111111,15));
    vecs.push_back(mk(0,1,1,32'h5550,32'hFFFF,15, 1,0,0, 3,0,0,1, 32'h100,32'h11111111,15));
    vecs.push_back(mk(0,0,0,0,0,0,             0,0,0, 3,0,0,1, 32'h100,32'h11111111,15));
    vecs.push_back(mk(0,0,0,0,0,0,             0,0,0, 3,0,0,1, 32'h100,32'h11111111,15));
    vecs.push_back(mk(0,0,0,0,0,0,             0,0,1, 3,0,0,1, 32'h100,32'h11111111,15));
    vecs.push_back(mk(0,0,0,0,0,0,             0,0,1, 3,0,0,1, 32'h1000,32'hAB00,2));
    vecs.push_back(mk(0,0,0,0,0,0,             0,0,1, 3,0,0,1, 32'h200,32'h22220000,12));
    vecs.push_back(mk(0,0,0,0,0,0,             0,0,0, 3,0,1,0, 0,0,0));
    // Fill to full across the index wrap, blocked dispatch, drain+dispatch.
    vecs.push_back(mk(1,0,0,0,0,0,             0,0,0, 3,0,1,0, 0,0,0));
    vecs.push_back(mk(1,1,3,32'h300,32'h33,1,  0,0,0, 4,0,0,0, 0,0,0));
    vecs.push_back(mk(1,1,4,32'h400,32'h44,1,  1,0,0, 5,0,0,0, 0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,             1,0,0, 6,0,0,1, 32'h300,32'h33,1));
    vecs.push_back(mk(1,0,0,0,0,0,             0,0,0, 7,0,0,1, 32'h300,32'h33,1));
    vecs.push_back(mk(1,0,0,0,0,0,             0,0,0, 0,0,0,1, 32'h300,32'h33,1));
    vecs.push_back(mk(1,0,0,0,0,0,             0,0,0, 1,0,0,1, 32'h300,32'h33,1));
    vecs.push_back(mk(1,0,0,0,0,0,             0,0,0, 2,0,0,1, 32'h300,32'h33,1));
    vecs.push_back(mk(1,0,0,0,0,0,             0,0,0, 3,1,0,1, 32'h300,32'h33,1));
    vecs.push_back(mk(1,0,0,0,0,0,             0,0,1, 3,1,0,1, 32'h300,32'h33,1));
    vecs.push_back(mk(1,0,0,0,0,0,             0,0,1, 3,0,0,1, 32'h400,32'h44,1));
    vecs.push_back(mk(1,0,0,0,0,0,             0,0,0, 4,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,             0,0,0, 5,1,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,             0,1,0, 5,1,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,             0,0,0, 5,0,1,0, 0,0,0));
    // Set up a pending drain for the asynchronous reset check.
    vecs.push_back(mk(1,0,0,0,0,0,             0,0,0, 5,0,1,0, 0,0,0));
    vecs.push_back(mk(0,1,5,32'h500,32'h55,3,  0,0,0, 6,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,             1,0,0, 6,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,             0,0,0, 6,0,0,1, 32'h500,32'h55,3));
    run_table("a");

    @(negedge clock);
    idle_inputs();
    #1;
    chk("pre-rst mem_valid", 32'(mem_req_valid), 32'd1);
    chk("pre-rst mem_addr",  mem_req_addr,       32'h500);
    #1 reset = 1'b0;
    #1;
    chk("async-rst mem_valid", 32'(mem_req_valid),    32'd0);
    chk("async-rst mem_addr",  mem_req_addr,          32'd0);
    chk("async-rst mem_data",  mem_req_data,          32'd0);
    chk("async-rst mem_bytes", 32'(mem_req_usebytes), 32'd0);
    chk("async-rst sq_empty",  32'(sq_empty),         32'd1);
    chk("async-rst sq_tail",   32'(sq_tail),          32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Squash with same-cycle retire, dispatch and exec.
    vecs.push_back(mk(1,0,0,0,0,0,              0,0,0, 0,0,1,0, 0,0,0));
    vecs.push_back(mk(1,1,0,32'hA00,32'hA0,15,  0,0,0, 1,0,0,0, 0,0,0));
    vecs.push_back(mk(1,1,1,32'hA10,32'hA1,15,  0,0,0, 2,0,0,0, 0,0,0));
    vecs.push_back(mk(1,1,2,32'hA20,32'hA2,15,  1,0,0, 3,0,0,0, 0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,              1,0,0, 4,0,0,1, 32'hA00,32'hA0,15));
    vecs.push_back(mk(1,1,3,32'hBAD0,32'hBAD,15, 1,1,0, 5,0,0,1, 32'hA00,32'hA0,15));
    vecs.push_back(mk(1,0,0,0,0,0,              0,0,0, 3,0,0,1, 32'hA00,32'hA0,15));
    vecs.push_back(mk(0,0,0,0,0,0,              1,0,1, 4,0,0,1, 32'hA00,32'hA0,15));
    vecs.push_back(mk(0,0,0,0,0,0,              0,0,1, 4,0,0,1, 32'hA10,32'hA1,15));
    vecs.push_back(mk(0,0,0,0,0,0,              0,0,1, 4,0,0,1, 32'hA20,32'hA2,15));
    vecs.push_back(mk(0,0,0,0,0,0,              0,0,0, 4,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,              0,1,0, 4,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,              0,0,0, 3,0,1,0, 0,0,0));
    run_table("b");

`ifdef SQ_FWD_EN
    vecs.push_back(mk(1,0,0,0,0,0,                  0,0,0, 3,0,1,0, 0,0,0));
    vecs.push_back(mk(1,1,3,32'h2000,32'h11223344,15, 0,0,0, 4,0,0,0, 0,0,0));
    vecs.push_back(mk(0,1,4,32'h2000,32'h00009900,2,  0,0,0, 5,0,0,0, 0,0,0));
    run_table("c");

    @(negedge clock);
    idle_inputs();
    ld_addr = 32'h2000;
    ld_pos  = 4'd5;
    #1;
    chk("fwd both bytes", 32'(ld_fwd_bytes), 32'hF);
    chk("fwd both data",  ld_fwd_data,       32'h11229944);
    ld_pos  = 4'd4;
    #1;
    chk("fwd older bytes", 32'(ld_fwd_bytes), 32'hF);
    chk("fwd older data",  ld_fwd_data,       32'h11223344);
    ld_pos  = 4'd3;
    #1;
    chk("fwd none bytes", 32'(ld_fwd_bytes), 32'h0);
    chk("fwd none data",  ld_fwd_data,       32'h0);
    ld_pos  = 4'd5;
    ld_addr = 32'h2004;
    #1;
    chk("fwd miss bytes", 32'(ld_fwd_bytes), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
